// File: rtl/pagerank_gather_multilane.sv
// pagerank_gather_multilane
// Multi-lane gather/accumulate stage of the PageRank pipeline. Each cycle in
// ACCUM up to NUM_LANES (dest id, value) contributions are captured into a
// stage register. On the following edge they are summed into per-node
// saturating accumulators. Same-cycle hits on one node are merged, and ids
// outside the graph are counted and dropped. An FSM frames each iteration
// through IDLE -> ACCUM -> DRAIN -> DONE.
//
// Ports
//   clock, reset_n   : system clock, asynchronous active-low reset
//   i_start          : pulse in IDLE/DONE; clears state and opens an iteration
//   i_in_valid       : per-lane contribution valid
//   i_in_dest_id     : per-lane destination id, lane k at [k*ID_WIDTH +: ID_WIDTH]
//   i_in_value       : per-lane contribution, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_in_ready       : high in ACCUM only; lanes are sampled only then
//   i_scatter_done   : end of scatter; contributions on that cycle still count
//   i_rd_addr        : accumulator read index
//   o_rd_data        : combinational acc[i_rd_addr], 0 when the index is out of range
//   o_gather_done    : high in DONE
//   o_overflow       : sticky, set when any accumulator saturated this iteration
//   o_drop_count     : saturating count of rejected out-of-range contributions
module pagerank_gather_multilane #(
  parameter int NODES_IN_GRAPH = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 32,
  parameter int NUM_LANES      = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              i_start,
  input  logic [NUM_LANES-1:0]              i_in_valid,
  input  logic [NUM_LANES*ID_WIDTH-1:0]     i_in_dest_id,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   i_in_value,
  output logic                              o_in_ready,
  input  logic                              i_scatter_done,
  input  logic [$clog2(NODES_IN_GRAPH)-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]             o_rd_data,
  output logic                              o_gather_done,
  output logic                              o_overflow,
  output logic [15:0]                       o_drop_count
);

  // Extra headroom bits so a full set of lanes plus the old value never wraps.
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_LANES + 1);
  localparam logic [ID_WIDTH-1:0] ID_LIMIT = ID_WIDTH'(NODES_IN_GRAPH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_clear;

  logic [NUM_LANES-1:0]  r_s1_valid;
  logic [ID_WIDTH-1:0]   r_s1_id    [NUM_LANES];
  logic [DATA_WIDTH-1:0] r_s1_value [NUM_LANES];

  logic [DATA_WIDTH-1:0] r_acc      [NODES_IN_GRAPH];
  logic [DATA_WIDTH-1:0] w_acc_next [NODES_IN_GRAPH];
  logic [NODES_IN_GRAPH-1:0] w_sat;
  logic                  r_overflow;
  logic [15:0]           r_drop_count;
  logic [15:0]           w_drop_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_ACCUM;
      S_ACCUM: if (i_scatter_done) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  if (i_start) w_next_state = S_ACCUM;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready    = (r_state == S_ACCUM);
    o_gather_done = (r_state == S_DONE);
    w_clear       = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // S1 only holds valid lanes captured during ACCUM, so it drains by itself
  // one cycle after ACCUM ends (the DRAIN cycle commits the last capture).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_s1_id[k]    <= '0;
        r_s1_value[k] <= '0;
      end
    end else begin
      r_s1_valid <= (r_state == S_ACCUM) ? i_in_valid : '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_s1_id[k]    <= i_in_dest_id[k*ID_WIDTH +: ID_WIDTH];
        r_s1_value[k] <= i_in_value[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Every node independently sums all S1 lanes that target it, which merges
  // collisions and gives single-cycle read-modify-write with no hazards.
  // Out-of-range ids never match a node, so they fall out naturally here.
  always_comb begin
    logic [SUM_WIDTH-1:0] v_sum;
    v_sum = '0;
    w_sat = '0;
    for (int n = 0; n < NODES_IN_GRAPH; n++) begin
      v_sum = SUM_WIDTH'(r_acc[n]);
      for (int k = 0; k < NUM_LANES; k++) begin
        if (r_s1_valid[k] && (r_s1_id[k] == ID_WIDTH'(n)))
          v_sum = v_sum + SUM_WIDTH'(r_s1_value[k]);
      end
      if (v_sum[SUM_WIDTH-1:DATA_WIDTH] != '0) begin
        w_acc_next[n] = '1;
        w_sat[n]      = 1'b1;
      end else begin
        w_acc_next[n] = v_sum[DATA_WIDTH-1:0];
      end
    end
  end

  // One extra bit detects wrap past 16'hFFFF so the counter can pin there.
  always_comb begin
    logic [16:0] v_count;
    v_count = {1'b0, r_drop_count};
    for (int k = 0; k < NUM_LANES; k++) begin
      if (r_s1_valid[k] && (r_s1_id[k] >= ID_LIMIT))
        v_count = v_count + 17'd1;
    end
    w_drop_next = v_count[16] ? 16'hFFFF : v_count[15:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NODES_IN_GRAPH; n++) r_acc[n] <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_clear) begin
      for (int n = 0; n < NODES_IN_GRAPH; n++) r_acc[n] <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      for (int n = 0; n < NODES_IN_GRAPH; n++) r_acc[n] <= w_acc_next[n];
      r_overflow   <= r_overflow | (|w_sat);
      r_drop_count <= w_drop_next;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (int'(i_rd_addr) < NODES_IN_GRAPH) o_rd_data = r_acc[i_rd_addr];
  end

  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_pagerank_gather_multilane.sv
// tb_pagerank_gather_multilane
// Self-checking bench for pagerank_gather_multilane. A reference model keeps
// one accumulator per node and adds each accepted cycle's contributions with
// plain wide arithmetic, saturation and drop counting. It is compared with
// the DUT through the read port once an iteration reaches DONE.
module tb_pagerank_gather_multilane;

  localparam int NODES = 32;
  localparam int DW    = 64;
  localparam int IDW   = 32;
  localparam int NL    = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            i_start = 1'b0;
  logic [NL-1:0]   i_in_valid = '0;
  logic [NL*IDW-1:0] i_in_dest_id = '0;
  logic [NL*DW-1:0]  i_in_value = '0;
  logic            o_in_ready;
  logic            i_scatter_done = 1'b0;
  logic [4:0]      i_rd_addr = '0;
  logic [DW-1:0]   o_rd_data;
  logic            o_gather_done;
  logic            o_overflow;
  logic [15:0]     o_drop_count;

  pagerank_gather_multilane #(
    .NODES_IN_GRAPH(NODES), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .NUM_LANES(NL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .i_start(i_start),
    .i_in_valid(i_in_valid), .i_in_dest_id(i_in_dest_id), .i_in_value(i_in_value),
    .o_in_ready(o_in_ready), .i_scatter_done(i_scatter_done),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_gather_done(o_gather_done), .o_overflow(o_overflow),
    .o_drop_count(o_drop_count)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state and the bench's own view of whether lanes are open.
  logic [DW-1:0] m_acc [NODES];
  logic          m_ovf;
  int            m_drop;
  bit            tb_accum;

  task automatic model_reset();
    for (int n = 0; n < NODES; n++) m_acc[n] = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_cycle(input logic [1:0] v, input logic [31:0] id0,
                             input logic [63:0] val0, input logic [31:0] id1,
                             input logic [63:0] val1);
    logic [65:0] total;
    for (int n = 0; n < NODES; n++) begin
      total = {2'b00, m_acc[n]};
      if (v[0] && id0 == n) total = total + {2'b00, val0};
      if (v[1] && id1 == n) total = total + {2'b00, val1};
      if (total > 66'h0_FFFF_FFFF_FFFF_FFFF) begin
        m_acc[n] = '1;
        m_ovf    = 1'b1;
      end else begin
        m_acc[n] = total[63:0];
      end
    end
    if (v[0] && id0 >= NODES) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
    if (v[1] && id1 >= NODES) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
  endtask

  // One input cycle; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] id0,
                               input logic [63:0] val0, input logic [31:0] id1,
                               input logic [63:0] val1, input logic sd);
    bit was_accum;
    i_in_valid     = v;
    i_in_dest_id   = {id1, id0};
    i_in_value     = {val1, val0};
    i_scatter_done = sd;
    was_accum      = tb_accum;
    if (was_accum) model_cycle(v, id0, val0, id1, val1);
    @(posedge clock);
    #1;
    if (was_accum && sd) tb_accum = 1'b0;
    i_in_valid     = '0;
    i_scatter_done = 1'b0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(posedge clock);
    #1;
    i_start = 1'b0;
    if (!tb_accum) begin
      model_reset();
      tb_accum = 1'b1;
    end
  endtask

  // Walks DRAIN into DONE after the scatter_done cycle.
  task automatic finish_iter();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    i_start    = 1'b1;
    i_in_valid = 2'b11;
    model_reset();
    tb_accum = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (o_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset in_ready: got %0b expected 0", o_in_ready); end
    tests_run++;
    if (o_gather_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset gather_done: got %0b expected 0", o_gather_done); end
    tests_run++;
    if (o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset overflow: got %0b expected 0", o_overflow); end
    tests_run++;
    if (o_drop_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset drop_count: got %0d expected 0", o_drop_count); end
    for (int n = 0; n < NODES; n += 7) begin
      i_rd_addr = 5'(n);
      @(negedge clock);
      tests_run++;
      if (o_rd_data !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset acc[%0d]: got %0h expected 0", n, o_rd_data); end
    end
    i_start    = 1'b0;
    i_in_valid = '0;
    reset_n    = 1'b1;
    @(negedge clock);
    // Lanes and scatter_done in IDLE must be ignored.
    applyStimulus(2'b11, 3, 50, 4, 60, 1'b1);
    @(negedge clock);
    tests_run++;
    if (o_in_ready !== 1'b0 || o_gather_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle ignores inputs: got ready=%0b done=%0b expected 0 0", o_in_ready, o_gather_done);
    end
    i_rd_addr = 5'd3;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd0) begin tests_failed++; $display("[TB] FAIL idle acc[3]: got %0h expected 0", o_rd_data); end
  endtask

  task automatic test_basic();
    do_start();
    tests_run++;
    if (o_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic in_ready: got %0b expected 1", o_in_ready); end
    i_rd_addr = 5'd3;
    applyStimulus(2'b01, 3, 100, 0, 0, 1'b0);
    tests_run++;
    if (o_rd_data !== 64'd0) begin tests_failed++; $display("[TB] FAIL basic latency early: got %0h expected 0", o_rd_data); end
    applyStimulus(2'b10, 0, 0, 5, 7, 1'b0);
    tests_run++;
    if (o_rd_data !== 64'd100) begin tests_failed++; $display("[TB] FAIL basic latency t+2: got %0h expected 64", o_rd_data); end
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1);
    tests_run++;
    if (o_gather_done !== 1'b0 || o_in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic drain: got done=%0b ready=%0b expected 0 0", o_gather_done, o_in_ready);
    end
    finish_iter();
    tests_run++;
    if (o_gather_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic gather_done: got %0b expected 1", o_gather_done); end
    i_rd_addr = 5'd5;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd7) begin tests_failed++; $display("[TB] FAIL basic acc[5]: got %0h expected 7", o_rd_data); end
    for (int n = 0; n < NODES; n++) begin
      i_rd_addr = 5'(n);
      @(negedge clock);
      tests_run++;
      if (o_rd_data !== m_acc[n]) begin tests_failed++; $display("[TB] FAIL basic acc[%0d]: got %0h expected %0h", n, o_rd_data, m_acc[n]); end
    end
  endtask

  task automatic test_collision();
    do_start();
    applyStimulus(2'b11, 4, 10, 4, 20, 1'b0);
    applyStimulus(2'b01, 4, 5, 0, 0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1);
    finish_iter();
    i_rd_addr = 5'd4;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd35) begin tests_failed++; $display("[TB] FAIL collision acc[4]: got %0h expected 23", o_rd_data); end
    tests_run++;
    if (o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL collision overflow: got %0b expected 0", o_overflow); end
  endtask

  task automatic test_saturation();
    do_start();
    applyStimulus(2'b01, 2, 64'hFFFF_FFFF_FFFF_FFF6, 0, 0, 1'b0);
    applyStimulus(2'b11, 2, 6, 2, 6, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1);
    finish_iter();
    i_rd_addr = 5'd2;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("[TB] FAIL saturation acc[2]: got %0h expected all ones", o_rd_data); end
    tests_run++;
    if (o_overflow !== 1'b1 || m_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL saturation overflow: got %0b expected 1", o_overflow); end
    do_start();
    tests_run++;
    if (o_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart overflow: got %0b expected 0", o_overflow); end
    tests_run++;
    if (o_rd_data !== 64'd0) begin tests_failed++; $display("[TB] FAIL restart acc[2]: got %0h expected 0", o_rd_data); end
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1);
    finish_iter();
  endtask

  task automatic test_out_of_range();
    do_start();
    applyStimulus(2'b01, 31, 123, 0, 0, 1'b0);
    applyStimulus(2'b11, 32, 1, 40, 2, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1);
    finish_iter();
    tests_run++;
    if (o_drop_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL oor drop_count: got %0d expected 2", o_drop_count); end
    i_rd_addr = 5'd31;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd123) begin tests_failed++; $display("[TB] FAIL oor acc[31]: got %0h expected 7b", o_rd_data); end
    for (int n = 0; n < NODES; n++) begin
      i_rd_addr = 5'(n);
      @(negedge clock);
      tests_run++;
      if (o_rd_data !== m_acc[n]) begin tests_failed++; $display("[TB] FAIL oor acc[%0d]: got %0h expected %0h", n, o_rd_data, m_acc[n]); end
    end
  endtask

  task automatic test_framing();
    // Offered while DONE: must not land anywhere.
    applyStimulus(2'b11, 1, 77, 2, 88, 1'b0);
    @(negedge clock);
    i_rd_addr = 5'd1;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== m_acc[1]) begin tests_failed++; $display("[TB] FAIL done ignores lanes acc[1]: got %0h expected %0h", o_rd_data, m_acc[1]); end
    do_start();
    applyStimulus(2'b01, 6, 4, 0, 0, 1'b0);
    i_start = 1'b1;
    applyStimulus(2'b01, 6, 5, 0, 0, 1'b0);
    i_start = 1'b0;
    tests_run++;
    if (o_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL start in accum state: got ready=%0b expected 1", o_in_ready); end
    applyStimulus(2'b01, 1, 9, 0, 0, 1'b1);
    finish_iter();
    tests_run++;
    if (o_gather_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL framing gather_done: got %0b expected 1", o_gather_done); end
    i_rd_addr = 5'd1;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd9) begin tests_failed++; $display("[TB] FAIL framing last-cycle acc[1]: got %0h expected 9", o_rd_data); end
    i_rd_addr = 5'd6;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd9) begin tests_failed++; $display("[TB] FAIL framing start-in-accum acc[6]: got %0h expected 9", o_rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    do_start();
    for (int c = 0; c < 6; c++) begin
      a = 64'($urandom_range(0, 100000));
      b = 64'($urandom_range(0, 100000));
      applyStimulus(2'b11, 9, a, 9, b, (c == 5) ? 1'b1 : 1'b0);
    end
    finish_iter();
    i_rd_addr = 5'd9;
    @(negedge clock);
    tests_run++;
    if (o_rd_data !== m_acc[9]) begin tests_failed++; $display("[TB] FAIL back_to_back acc[9]: got %0h expected %0h", o_rd_data, m_acc[9]); end
  endtask

  task automatic test_random();
    logic [1:0]  v;
    logic [31:0] id0, id1;
    logic [63:0] val0, val1;
    int len;
    for (int it = 0; it < 8; it++) begin
      do_start();
      len = $urandom_range(3, 20);
      for (int c = 0; c < len; c++) begin
        v    = 2'($urandom_range(0, 3));
        id0  = $urandom_range(0, 39);
        id1  = ($urandom_range(0, 3) == 0) ? id0 : 32'($urandom_range(0, 39));
        val0 = ($urandom_range(0, 9) == 0) ? {4'hF, 28'($urandom), $urandom} : 64'($urandom_range(0, 1000));
        val1 = ($urandom_range(0, 9) == 0) ? {4'hF, 28'($urandom), $urandom} : 64'($urandom_range(0, 1000));
        i_start = ($urandom_range(0, 7) == 0);
        applyStimulus(v, id0, val0, id1, val1, (c == len - 1) ? 1'b1 : 1'b0);
        i_start = 1'b0;
      end
      finish_iter();
      tests_run++;
      if (o_overflow !== m_ovf) begin tests_failed++; $display("[TB] FAIL random[%0d] overflow: got %0b expected %0b", it, o_overflow, m_ovf); end
      tests_run++;
      if (o_drop_count !== 16'(m_drop)) begin tests_failed++; $display("[TB] FAIL random[%0d] drop_count: got %0d expected %0d", it, o_drop_count, m_drop); end
      for (int n = 0; n < NODES; n++) begin
        i_rd_addr = 5'(n);
        @(negedge clock);
        tests_run++;
        if (o_rd_data !== m_acc[n]) begin tests_failed++; $display("[TB] FAIL random[%0d] acc[%0d]: got %0h expected %0h", it, n, o_rd_data, m_acc[n]); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_start();
    applyStimulus(2'b01, 6, 11, 0, 0, 1'b0);
    applyStimulus(2'b01, 7, 55, 0, 0, 1'b0);
    i_rd_addr = 5'd6;
    #1;
    tests_run++;
    if (o_rd_data !== 64'd11) begin tests_failed++; $display("[TB] FAIL pre-reset acc[6]: got %0h expected b", o_rd_data); end
    #1;
    reset_n = 1'b0;
    model_reset();
    tb_accum = 1'b0;
    #1;
    tests_run++;
    if (o_rd_data !== 64'd0) begin tests_failed++; $display("[TB] FAIL async reset acc[6]: got %0h expected 0", o_rd_data); end
    tests_run++;
    if (o_in_ready !== 1'b0 || o_gather_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async reset state: got ready=%0b done=%0b expected 0 0", o_in_ready, o_gather_done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    i_rd_addr = 5'd7;
    repeat (2) @(negedge clock);
    tests_run++;
    if (o_rd_data !== 64'd0) begin tests_failed++; $display("[TB] FAIL async reset pending S1 acc[7]: got %0h expected 0", o_rd_data); end
    tests_run++;
    if (o_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL async reset idle: got ready=%0b expected 0", o_in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_saturation();
    test_out_of_range();
    test_framing();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pagerank_gather_multilane.md
Name: pagerank_gather_multilane

Overview:
Multi-lane, parametrised gather/accumulate stage for the PageRank pipeline. Accepts up to NUM_LANES scatter contributions per cycle and sums each into a per-node accumulator indexed by destination id. Same-cycle collisions are merged, out-of-range ids are rejected, and sums saturate on overflow. An FSM frames each iteration (start, accumulate, drain, done) and exposes a read port for the downstream damping stage.

Parameters:
NODES_IN_GRAPH, 32, number of accumulators (node ids 0..NODES_IN_GRAPH-1)
DATA_WIDTH, 64, unsigned fixed-point width of contributions and accumulators
ID_WIDTH, 32, width of each dest_id field
NUM_LANES, 2, parallel scatter input lanes (>=1)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  pulse: clear accumulators and begin an iteration
in_valid  input  NUM_LANES  per-lane contribution valid
in_dest_id  input  NUM_LANES*ID_WIDTH  per-lane destination id, lane k at [k*ID_WIDTH +: ID_WIDTH]
in_value  input  NUM_LANES*DATA_WIDTH  per-lane contribution, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
in_ready  output  1  high only in ACCUM; lanes are sampled only when in_ready=1
scatter_done  input  1  scatter phase finished; contributions on the same cycle are still taken
rd_addr  input  $clog2(NODES_IN_GRAPH)  accumulator read index
rd_data  output  DATA_WIDTH  combinational acc[rd_addr]; 0 if rd_addr>=NODES_IN_GRAPH
gather_done  output  1  high in DONE
overflow  output  1  sticky: some accumulator saturated this iteration
drop_count  output  16  number of rejected out-of-range contributions, saturating

Behaviour:
- Reset (async): state=IDLE; all accumulators=0; stage register invalid; in_ready=0, gather_done=0, overflow=0, drop_count=0.
- States: IDLE, ACCUM, DRAIN, DONE.
  - IDLE or DONE, start=1: clear all accumulators, overflow and drop_count at that edge; next state ACCUM.
  - ACCUM: scatter_done=1 -> DRAIN; start ignored.
  - DRAIN: lasts exactly 1 cycle -> DONE; start and scatter_done ignored.
  - DONE: holds until start; gather_done=1.
  - scatter_done outside ACCUM is ignored.
- Pipeline, 2 stages:
  - Cycle t, in ACCUM: lanes with in_valid=1 are captured into stage register S1 (valid, id, value per lane).
  - Edge ending cycle t+1: S1 commits to the accumulators. rd_data reflects the new value from cycle t+2.
  - S1 entries always commit, including during DRAIN. S1 is invalid whenever the previous state was not ACCUM.
- Collision merge: for each node n, new = acc[n] + sum of S1 values from valid lanes whose id==n.
  - Compute at DATA_WIDTH+$clog2(NUM_LANES+1) bits.
  - If the result exceeds 2^DATA_WIDTH-1, store all-ones and set overflow.
- Out-of-range: a valid S1 lane with id>=NODES_IN_GRAPH is not accumulated. drop_count increments by the number of such lanes that cycle and saturates at 16'hFFFF.
- Back-to-back updates to the same node on consecutive cycles must accumulate correctly. No lost updates and no stall; the accumulator is read-modify-write in a single cycle.
- No backpressure: in_ready is state-only. The producer must hold contributions while in_ready=0; contributions offered then are ignored.
- start coincident with reset deassertion: reset dominates while asserted.
- Async reset mid-iteration: everything returns to reset values immediately.

Test Plan:
- Reset, then start. Lane0 (id 3, 100) cycle 1; lane1 (id 5, 7) cycle 2; scatter_done cycle 3 -> rd_data@3=100, @5=7, others 0. gather_done rises 2 cycles after scatter_done.
- Collision: both lanes id 4, values 10 and 20 same cycle, then lane0 id 4 value 5 next cycle -> acc[4]=35, overflow=0.
- Saturation: DATA_WIDTH=64, acc[2]=2^64-10, add 6 and 6 in one cycle -> acc[2]=64'hFFFF_FFFF_FFFF_FFFF, overflow=1. A subsequent start clears overflow and acc[2]=0.
- Out-of-range: lane0 id 32, lane1 id 40 with NODES_IN_GRAPH=32 -> all accumulators unchanged, drop_count=2; rd_addr=31 reads normally.
- Framing: valids in IDLE or DONE are ignored. Contribution coincident with scatter_done (id 1, 9) -> acc[1]=9 visible when gather_done=1. start in ACCUM has no effect.
- Async reset asserted mid-ACCUM with S1 valid -> accumulators 0, state IDLE, pending S1 discarded, gather_done=0.
